// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard gating ID issue on RAW and per-register write-limit hazards
//   Ports: clk/rst (async, active-high); issue_* handshake and operands from ID;
//   wb_valid/wb_addr retire from WB; flush drops all pending writes;
//   busy_vec per-register pending flag; stall, stall_cnt (saturating), err (sticky bad retire).
//   Optional SB_WB_BYPASS_EN: hazard/full checks see the same-cycle retire.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic                issue_use_rs,
  input  logic                issue_use_rt,
  input  logic                issue_wr_en,
  input  logic [ADDR_W-1:0]   issue_wr_addr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                stall,
  output logic [STALL_W-1:0]  stall_cnt,
  output logic                err
);
  localparam logic [CNT_W-1:0] LIMIT = '1;
  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic [CNT_W-1:0] eff [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec;
  logic raw, full, accept, err_q, err_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  // dec never fires on r0 or on an empty counter, so r0 stays at zero forever
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      dec[i] = wb_valid & ~flush & (wb_addr == ADDR_W'(i)) & (i != 0) & (pend_q[i] != '0);
`ifdef SB_WB_BYPASS_EN
      eff[i] = pend_q[i] - CNT_W'(dec[i]);
`else
      eff[i] = pend_q[i];
`endif
      busy_vec[i] = pend_q[i] != '0;
    end
    raw = (issue_use_rs & (issue_rs != '0) & (eff[issue_rs] != '0)) |
          (issue_use_rt & (issue_rt != '0) & (eff[issue_rt] != '0));
    full = issue_wr_en & (issue_wr_addr != '0) & (eff[issue_wr_addr] == LIMIT);
    issue_ready = ~flush & ~raw & ~full;
    stall = issue_valid & ~issue_ready;
    accept = issue_valid & issue_ready;
  end
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = accept & issue_wr_en & (issue_wr_addr == ADDR_W'(i)) & (i != 0);
      pend_d[i] = flush ? '0 : pend_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end
    err_d = err_q | (wb_valid & ~flush & (wb_addr != '0) & (pend_q[wb_addr] == '0));
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + STALL_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
      err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
      err_q <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign err = err_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random stimulus against a behavioural pending-count model
module tb_reg_scoreboard;
  logic clk, rst, issue_valid, issue_ready, issue_use_rs, issue_use_rt, issue_wr_en;
  logic wb_valid, flush, stall, err;
  logic [4:0] issue_rs, issue_rt, issue_wr_addr, wb_addr;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  int pend [32];
  bit m_err;
  int m_scnt;
`ifdef SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  reg_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_use_rs(issue_use_rs),
    .issue_use_rt(issue_use_rt), .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .busy_vec(busy_vec),
    .stall(stall), .stall_cnt(stall_cnt), .err(err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    m_err = 0;
    m_scnt = 0;
  endtask
  // called just after a rising edge; drives one cycle, checks at the falling edge, advances the model
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit we, input int wa, input bit wbv, input int wba, input bit fl);
    bit dec, rdy, raw, full, bad;
    logic [31:0] bv;
    int e_rs, e_rt, e_wa;
    issue_valid = v; issue_rs = 5'(rs); issue_rt = 5'(rt); issue_use_rs = urs;
    issue_use_rt = urt; issue_wr_en = we; issue_wr_addr = 5'(wa);
    wb_valid = wbv; wb_addr = 5'(wba); flush = fl;
    dec = wbv && !fl && wba != 0 && pend[wba] > 0;
    bad = wbv && !fl && wba != 0 && pend[wba] == 0;
    e_rs = pend[rs] - int'(BYP && dec && wba == rs);
    e_rt = pend[rt] - int'(BYP && dec && wba == rt);
    e_wa = pend[wa] - int'(BYP && dec && wba == wa);
    raw = (urs && rs != 0 && e_rs > 0) || (urt && rt != 0 && e_rt > 0);
    full = we && wa != 0 && e_wa == 3;
    rdy = !fl && !raw && !full;
    bv = '0;
    for (int r = 1; r < 32; r++) bv[r] = pend[r] != 0;
    @(negedge clk);
    chk("ready", 32'(issue_ready), 32'(rdy));
    chk("stall", 32'(stall), 32'(v && !rdy));
    chk("busy_vec", busy_vec, bv);
    chk("err", 32'(err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    if (fl) foreach (pend[i]) pend[i] = 0;
    else begin
      if (dec) pend[wba]--;
      if (v && rdy && we && wa != 0) pend[wa]++;
    end
    if (bad) m_err = 1;
    if (v && !rdy && m_scnt < 65535) m_scnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1;
    step_init();
  end
  task automatic step_init();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_wr_en = 0; issue_wr_addr = 0; wb_valid = 0; wb_addr = 0; flush = 0;
    model_reset();
    #12;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_scnt", 32'(stall_cnt), 32'h0);
    #11 rst = 0;
    @(posedge clk);
    #1;
    // RAW on r8, resolved by WB
    step(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    chk("t1_busy", busy_vec, 32'h0000_0100);
    repeat (3) step(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t1_scnt", 32'(stall_cnt), 32'd3);
    step(1, 8, 0, 1, 0, 0, 0, 1, 8, 0);
    step(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    // write limit on r5
    repeat (3) step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("t2_full", 32'(issue_ready), 32'h0);
    step(1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    // simultaneous issue and retire on r9
    step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    chk("t3_busy9", 32'(busy_vec[9]), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    // r0 is never tracked
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    chk("t4_busy0", 32'(busy_vec[0]), 32'h0);
    chk("t4_err", 32'(err), 32'h0);
    // flush beats issue and retire
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 3, 0, 1, 0, 1, 10, 1, 3, 1);
    chk("fl_busy", busy_vec, 32'h0);
    chk("fl_err", 32'(err), 32'h0);
    idle();
    // retire to empty r12 sets sticky err
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    chk("t5_err", 32'(err), 32'h1);
    repeat (3) step(1, 0, 0, 0, 0, 1, 6, 1, 6, 0);
    chk("t5_sticky", 32'(err), 32'h1);
    for (int k = 0; k < 1500; k++)
      step($urandom % 4 != 0, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom % 3 == 0,
           $urandom_range(0, 7), $urandom % 20 == 0);
    // async reset mid-stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    repeat (2) step(1, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    #3 rst = 1;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_scnt", 32'(stall_cnt), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    model_reset();
    #2 rst = 0;
    @(posedge clk);
    #1;
    step(1, 8, 0, 1, 0, 1, 8, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask
endmodule
